// File: rtl/mem_port_arbiter_if.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter_if
//   Groups the three request/response channels around the shared memory port
//   into one bundle.
//
//   Fetch channel : if_req_valid/if_req_ready/if_addr,
//                   if_rsp_valid/if_rsp_data/if_rsp_err
//   LSU channel   : lsu_req_valid/lsu_req_ready/lsu_we/lsu_be/lsu_addr/
//                   lsu_wdata, lsu_rsp_valid/lsu_rsp_rdata/lsu_rsp_err
//   Memory channel: mem_req_valid/mem_req_ready/mem_we/mem_be/mem_addr/
//                   mem_wdata, mem_rsp_valid/mem_rsp_rdata
//
//   Modports:
//     slave  - the arbiter's view (drives readies, responses, memory request)
//     master - the surrounding core/memory view (the opposite directions)
//
//   Handshake rule: a request transfers on a cycle where valid and ready are
//   both high. Valid may not depend on ready. Response *_rsp_valid signals are
//   single-cycle pulses with no back-pressure.
// ----------------------------------------------------------------------------
interface mem_port_arbiter_if;
    logic        if_req_valid;
    logic        if_req_ready;
    logic [31:0] if_addr;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_data;
    logic        if_rsp_err;

    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic        lsu_we;
    logic [3:0]  lsu_be;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic        lsu_rsp_valid;
    logic [31:0] lsu_rsp_rdata;
    logic        lsu_rsp_err;

    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_rdata;

    modport slave (
        input  if_req_valid, if_addr,
        output if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
        input  lsu_req_valid, lsu_we, lsu_be, lsu_addr, lsu_wdata,
        output lsu_req_ready, lsu_rsp_valid, lsu_rsp_rdata, lsu_rsp_err,
        output mem_req_valid, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
    );

    modport master (
        output if_req_valid, if_addr,
        input  if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
        output lsu_req_valid, lsu_we, lsu_be, lsu_addr, lsu_wdata,
        input  lsu_req_ready, lsu_rsp_valid, lsu_rsp_rdata, lsu_rsp_err,
        input  mem_req_valid, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one memory port between instruction fetch (read-only) and the
//   load/store unit. One transaction is outstanding at a time. The LSU has
//   fixed priority, but after STARVE_LIMIT consecutive LSU grants made while
//   fetch was waiting, fetch is granted.
//
//   Ports:
//     clk         - clock, rising edge
//     rst         - synchronous, active-high reset
//     bus         - mem_port_arbiter_if.slave (fetch, LSU and memory channels)
//     dbg_state_o - current FSM state (IDLE=0, ISSUE=1, WAIT_RSP=2, DRAIN=3)
//
//   Optional build macro ARB_RSP_TIMEOUT_EN: adds a response watchdog. After
//   TIMEOUT_CYCLES cycles in WAIT_RSP without a response the owner gets an
//   error response and the FSM sits in DRAIN until the late response arrives.
//   Without it, WAIT_RSP waits forever and the rsp_err outputs are 0.
// ----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_port_arbiter_if.slave    bus,
    output logic [1:0]           dbg_state_o
);
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, DRAIN} state_e;

    state_e        state_q, state_d;
    logic          owner_lsu_q, owner_lsu_d;
    logic          we_q, we_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [SW-1:0] streak_q, streak_d;
    logic          if_rsp_valid_q, if_rsp_valid_d;
    logic [31:0]   if_rsp_data_q, if_rsp_data_d;
    logic          lsu_rsp_valid_q, lsu_rsp_valid_d;
    logic [31:0]   lsu_rsp_rdata_q, lsu_rsp_rdata_d;
    logic          if_ready, lsu_ready;
    logic          force_if, lsu_win;

`ifdef ARB_RSP_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic          if_rsp_err_q, if_rsp_err_d;
    logic          lsu_rsp_err_q, lsu_rsp_err_d;
`endif

    // The low fetch address bits are dropped (word-aligned fetch); the
    // timeout parameter is only consumed when the watchdog is built in.
    logic unused_bits;
    assign unused_bits = ^bus.if_addr[1:0] ^ (TIMEOUT_CYCLES != 0);

    // Fetch is forced only when the LSU streak is exhausted and fetch waits.
    assign force_if = (streak_q == SW'(STARVE_LIMIT)) && bus.if_req_valid;
    assign lsu_win  = bus.lsu_req_valid && !force_if;

    always_comb begin
        state_d         = state_q;
        owner_lsu_d     = owner_lsu_q;
        we_d            = we_q;
        be_d            = be_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        streak_d        = streak_q;
        if_rsp_valid_d  = 1'b0;
        if_rsp_data_d   = if_rsp_data_q;
        lsu_rsp_valid_d = 1'b0;
        lsu_rsp_rdata_d = lsu_rsp_rdata_q;
        if_ready        = 1'b0;
        lsu_ready       = 1'b0;
`ifdef ARB_RSP_TIMEOUT_EN
        tmo_d           = tmo_q;
        if_rsp_err_d    = if_rsp_err_q;
        lsu_rsp_err_d   = lsu_rsp_err_q;
`endif
        case (state_q)
            IDLE: begin
                // Readies are gated by rst so nothing looks accepted in reset.
                if (!rst && lsu_win) begin
                    lsu_ready   = 1'b1;
                    owner_lsu_d = 1'b1;
                    we_d        = bus.lsu_we;
                    be_d        = bus.lsu_be;
                    addr_d      = bus.lsu_addr;
                    wdata_d     = bus.lsu_wdata;
                    streak_d    = bus.if_req_valid ? streak_q + SW'(1) : '0;
                    state_d     = ISSUE;
                end else if (!rst && bus.if_req_valid) begin
                    if_ready    = 1'b1;
                    owner_lsu_d = 1'b0;
                    we_d        = 1'b0;
                    be_d        = 4'hF;
                    addr_d      = {bus.if_addr[31:2], 2'b00};
                    wdata_d     = '0;
                    streak_d    = '0;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.mem_req_ready) begin
                    state_d = WAIT_RSP;
`ifdef ARB_RSP_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end
            end
            WAIT_RSP: begin
                if (bus.mem_rsp_valid) begin
                    if (owner_lsu_q) begin
                        lsu_rsp_valid_d = 1'b1;
                        lsu_rsp_rdata_d = bus.mem_rsp_rdata;
                    end else begin
                        if_rsp_valid_d  = 1'b1;
                        if_rsp_data_d   = bus.mem_rsp_rdata;
                    end
`ifdef ARB_RSP_TIMEOUT_EN
                    if (owner_lsu_q) lsu_rsp_err_d = 1'b0;
                    else             if_rsp_err_d  = 1'b0;
                    tmo_d = '0;
`endif
                    state_d = IDLE;
                end
`ifdef ARB_RSP_TIMEOUT_EN
                else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    // This is the last allowed WAIT_RSP cycle: report an error.
                    if (owner_lsu_q) begin
                        lsu_rsp_valid_d = 1'b1;
                        lsu_rsp_rdata_d = '0;
                        lsu_rsp_err_d   = 1'b1;
                    end else begin
                        if_rsp_valid_d  = 1'b1;
                        if_rsp_data_d   = '0;
                        if_rsp_err_d    = 1'b1;
                    end
                    state_d = DRAIN;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
`endif
            end
`ifdef ARB_RSP_TIMEOUT_EN
            DRAIN: begin
                // The late response belongs to the abandoned request: drop it.
                if (bus.mem_rsp_valid) state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            owner_lsu_q     <= 1'b0;
            we_q            <= 1'b0;
            be_q            <= '0;
            addr_q          <= '0;
            wdata_q         <= '0;
            streak_q        <= '0;
            if_rsp_valid_q  <= 1'b0;
            if_rsp_data_q   <= '0;
            lsu_rsp_valid_q <= 1'b0;
            lsu_rsp_rdata_q <= '0;
        end else begin
            state_q         <= state_d;
            owner_lsu_q     <= owner_lsu_d;
            we_q            <= we_d;
            be_q            <= be_d;
            addr_q          <= addr_d;
            wdata_q         <= wdata_d;
            streak_q        <= streak_d;
            if_rsp_valid_q  <= if_rsp_valid_d;
            if_rsp_data_q   <= if_rsp_data_d;
            lsu_rsp_valid_q <= lsu_rsp_valid_d;
            lsu_rsp_rdata_q <= lsu_rsp_rdata_d;
        end
    end

`ifdef ARB_RSP_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q         <= '0;
            if_rsp_err_q  <= 1'b0;
            lsu_rsp_err_q <= 1'b0;
        end else begin
            tmo_q         <= tmo_d;
            if_rsp_err_q  <= if_rsp_err_d;
            lsu_rsp_err_q <= lsu_rsp_err_d;
        end
    end
    assign bus.if_rsp_err  = if_rsp_err_q;
    assign bus.lsu_rsp_err = lsu_rsp_err_q;
`else
    assign bus.if_rsp_err  = 1'b0;
    assign bus.lsu_rsp_err = 1'b0;
`endif

    assign bus.if_req_ready  = if_ready;
    assign bus.lsu_req_ready = lsu_ready;
    assign bus.mem_req_valid = (state_q == ISSUE);
    assign bus.mem_we        = we_q;
    assign bus.mem_be        = be_q;
    assign bus.mem_addr      = addr_q;
    assign bus.mem_wdata     = wdata_q;
    assign bus.if_rsp_valid  = if_rsp_valid_q;
    assign bus.if_rsp_data   = if_rsp_data_q;
    assign bus.lsu_rsp_valid = lsu_rsp_valid_q;
    assign bus.lsu_rsp_rdata = lsu_rsp_rdata_q;
    assign dbg_state_o       = state_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter. Inputs change 1 time unit after the
//   rising edge; outputs are checked 1 more unit later, away from the edge.
// ----------------------------------------------------------------------------
module tb_mem_port_arbiter;
    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;
    int         n_assert;
    int         n_fail;

    mem_port_arbiter_if bus();

`ifdef ARB_RSP_TIMEOUT_EN
    mem_port_arbiter #(.STARVE_LIMIT(4), .TIMEOUT_CYCLES(8)) dut (
`else
    mem_port_arbiter #(.STARVE_LIMIT(4), .TIMEOUT_CYCLES(64)) dut (
`endif
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench watchdog expired");
    end

    // checker
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Called in an ISSUE cycle with mem_req_ready driven 1: memory accepts,
    // responds one cycle later, and the bench returns in the pulse cycle.
    task automatic mem_serve(input logic [31:0] rdata);
        tick();
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_rdata = rdata;
        tick();
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_rdata = '0;
        settle();
    endtask

    logic exp_lsu_grant [10];

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus.if_req_valid  = 1'b1;
        bus.if_addr       = 32'h0;
        bus.lsu_req_valid = 1'b1;
        bus.lsu_we        = 1'b0;
        bus.lsu_be        = 4'h0;
        bus.lsu_addr      = 32'h0;
        bus.lsu_wdata     = 32'h0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_rdata = 32'h0;
        tick();
        tick();
        settle();

        // reset state: outputs 0 even with requests present
        chk("rst_if_ready",  bus.if_req_ready, 0);
        chk("rst_lsu_ready", bus.lsu_req_ready, 0);
        chk("rst_mem_valid", bus.mem_req_valid, 0);
        chk("rst_mem_addr",  bus.mem_addr, 0);
        chk("rst_mem_be",    bus.mem_be, 0);
        chk("rst_if_rsp",    bus.if_rsp_valid, 0);
        chk("rst_lsu_rsp",   bus.lsu_rsp_valid, 0);
        chk("rst_state",     dbg_state, 0);

        // 1: fetch alone, unaligned address
        bus.if_req_valid  = 1'b0;
        bus.lsu_req_valid = 1'b0;
        rst = 1'b0;
        tick();
        bus.if_req_valid  = 1'b1;
        bus.if_addr       = 32'h0000_1003;
        bus.mem_req_ready = 1'b1;
        settle();
        chk("t1_if_ready",  bus.if_req_ready, 1);
        chk("t1_lsu_ready", bus.lsu_req_ready, 0);
        tick();
        bus.if_req_valid = 1'b0;
        settle();
        chk("t1_mem_valid", bus.mem_req_valid, 1);
        chk("t1_mem_addr",  bus.mem_addr, 32'h0000_1000);
        chk("t1_mem_we",    bus.mem_we, 0);
        chk("t1_mem_be",    bus.mem_be, 4'hF);
        chk("t1_mem_wdata", bus.mem_wdata, 0);
        mem_serve(32'hDEAD_BEEF);
        chk("t1_if_rsp",    bus.if_rsp_valid, 1);
        chk("t1_if_data",   bus.if_rsp_data, 32'hDEAD_BEEF);
        chk("t1_if_err",    bus.if_rsp_err, 0);
        chk("t1_lsu_rsp",   bus.lsu_rsp_valid, 0);
        tick();
        chk("t1_if_rsp_end", bus.if_rsp_valid, 0);
        chk("t1_if_data_hold", bus.if_rsp_data, 32'hDEAD_BEEF);

        // 2: both request; LSU store wins, fetch follows
        bus.if_req_valid  = 1'b1;
        bus.if_addr       = 32'h0000_3006;
        bus.lsu_req_valid = 1'b1;
        bus.lsu_we        = 1'b1;
        bus.lsu_be        = 4'h3;
        bus.lsu_addr      = 32'h0000_2000;
        bus.lsu_wdata     = 32'h0000_1234;
        settle();
        chk("t2_lsu_ready", bus.lsu_req_ready, 1);
        chk("t2_if_ready",  bus.if_req_ready, 0);
        tick();
        bus.lsu_req_valid = 1'b0;
        settle();
        chk("t2_mem_we",    bus.mem_we, 1);
        chk("t2_mem_be",    bus.mem_be, 4'h3);
        chk("t2_mem_addr",  bus.mem_addr, 32'h0000_2000);
        chk("t2_mem_wdata", bus.mem_wdata, 32'h0000_1234);
        chk("t2_if_ready_busy", bus.if_req_ready, 0);
        mem_serve(32'hAAAA_5555);
        chk("t2_lsu_rsp",   bus.lsu_rsp_valid, 1);
        chk("t2_lsu_data",  bus.lsu_rsp_rdata, 32'hAAAA_5555);
        chk("t2_if_rsp",    bus.if_rsp_valid, 0);
        chk("t2_if_ready",  bus.if_req_ready, 1);
        tick();
        bus.if_req_valid = 1'b0;
        settle();
        chk("t2_if_addr",   bus.mem_addr, 32'h0000_3004);
        mem_serve(32'h0BAD_F00D);
        chk("t2_if_rsp2",   bus.if_rsp_valid, 1);
        chk("t2_if_data2",  bus.if_rsp_data, 32'h0BAD_F00D);
        chk("t2_lsu_hold",  bus.lsu_rsp_rdata, 32'hAAAA_5555);

        // 3: continuous contention, starvation guard
        exp_lsu_grant = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        bus.lsu_we        = 1'b0;
        bus.lsu_be        = 4'hF;
        bus.if_req_valid  = 1'b1;
        bus.lsu_req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.lsu_addr = 32'h0000_8000 + 32'(i * 4);
            settle();
            chk($sformatf("t3_lsu_grant%0d", i), bus.lsu_req_ready, exp_lsu_grant[i]);
            chk($sformatf("t3_if_grant%0d", i),  bus.if_req_ready, !exp_lsu_grant[i]);
            tick();
            mem_serve(32'h5000_0000 + 32'(i));
            chk($sformatf("t3_lsu_rsp%0d", i), bus.lsu_rsp_valid, exp_lsu_grant[i]);
            chk($sformatf("t3_if_rsp%0d", i),  bus.if_rsp_valid, !exp_lsu_grant[i]);
        end
        bus.if_req_valid  = 1'b0;
        bus.lsu_req_valid = 1'b0;
        tick();

        // 4: memory stalls in ISSUE; stray response there is ignored
        bus.if_req_valid  = 1'b1;
        bus.if_addr       = 32'h0000_4008;
        bus.mem_req_ready = 1'b0;
        tick();
        bus.lsu_req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.mem_rsp_valid = (i == 2);
            bus.mem_rsp_rdata = 32'hFFFF_FFFF;
            settle();
            chk($sformatf("t4_valid%0d", i), bus.mem_req_valid, 1);
            chk($sformatf("t4_addr%0d", i),  bus.mem_addr, 32'h0000_4008);
            chk($sformatf("t4_be%0d", i),    bus.mem_be, 4'hF);
            chk($sformatf("t4_rdy%0d", i),   {bus.if_req_ready, bus.lsu_req_ready}, 0);
            chk($sformatf("t4_rsp%0d", i),   {bus.if_rsp_valid, bus.lsu_rsp_valid}, 0);
            tick();
        end
        bus.mem_rsp_valid = 1'b0;
        bus.if_req_valid  = 1'b0;
        bus.lsu_req_valid = 1'b0;
        bus.mem_req_ready = 1'b1;
        settle();
        chk("t4_rsp_after_stall", bus.if_rsp_valid, 0);
        mem_serve(32'h4444_0008);
        chk("t4_if_rsp",  bus.if_rsp_valid, 1);
        chk("t4_if_data", bus.if_rsp_data, 32'h4444_0008);

        // 5: reset in WAIT_RSP, late response ignored
        bus.if_req_valid = 1'b1;
        bus.if_addr      = 32'h0000_5000;
        tick();
        bus.if_req_valid = 1'b0;
        tick();
        settle();
        chk("t5_in_wait", dbg_state, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        chk("t5_state_idle", dbg_state, 0);
        chk("t5_mem_valid",  bus.mem_req_valid, 0);
        chk("t5_if_data_rst", bus.if_rsp_data, 0);
        tick();
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_rdata = 32'h5555_5555;
        tick();
        bus.mem_rsp_valid = 1'b0;
        settle();
        chk("t5_no_rsp", {bus.if_rsp_valid, bus.lsu_rsp_valid}, 0);
        tick();
        chk("t5_no_rsp2", {bus.if_rsp_valid, bus.lsu_rsp_valid}, 0);
        chk("t5_data_kept", bus.if_rsp_data, 0);
        bus.if_req_valid = 1'b1;
        bus.if_addr      = 32'h0000_6004;
        settle();
        chk("t5_if_ready", bus.if_req_ready, 1);
        tick();
        bus.if_req_valid = 1'b0;
        mem_serve(32'h600D_600D);
        chk("t5_if_rsp",  bus.if_rsp_valid, 1);
        chk("t5_if_data", bus.if_rsp_data, 32'h600D_600D);

`ifdef ARB_RSP_TIMEOUT_EN
        // 6: LSU load, no response, watchdog fires after 8 WAIT_RSP cycles
        bus.lsu_req_valid = 1'b1;
        bus.lsu_we        = 1'b0;
        bus.lsu_addr      = 32'h0000_7000;
        tick();
        bus.lsu_req_valid = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) begin
            settle();
            chk($sformatf("t6_wait%0d", i), dbg_state, 2);
            chk($sformatf("t6_norsp%0d", i), bus.lsu_rsp_valid, 0);
            tick();
        end
        settle();
        chk("t6_lsu_rsp",  bus.lsu_rsp_valid, 1);
        chk("t6_lsu_err",  bus.lsu_rsp_err, 1);
        chk("t6_lsu_data", bus.lsu_rsp_rdata, 0);
        chk("t6_drain",    dbg_state, 3);
        bus.lsu_req_valid = 1'b1;
        bus.lsu_addr      = 32'h0000_7004;
        settle();
        chk("t6_drain_no_ready", bus.lsu_req_ready, 0);
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_rdata = 32'h1111_1111;
        tick();
        bus.mem_rsp_valid = 1'b0;
        settle();
        chk("t6_discard", bus.lsu_rsp_valid, 0);
        chk("t6_idle",    dbg_state, 0);
        chk("t6_ready",   bus.lsu_req_ready, 1);
        tick();
        bus.lsu_req_valid = 1'b0;
        mem_serve(32'h2222_2222);
        chk("t6_ok_rsp",  bus.lsu_rsp_valid, 1);
        chk("t6_ok_err",  bus.lsu_rsp_err, 0);
        chk("t6_ok_data", bus.lsu_rsp_rdata, 32'h2222_2222);
`else
        chk("t6_if_err_tied",  bus.if_rsp_err, 0);
        chk("t6_lsu_err_tied", bus.lsu_rsp_err, 0);
`endif

        // final report
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the core's single memory port between instruction fetch (read-only) and the load/store unit (read/write).
- One outstanding transaction at a time.
- LSU has fixed priority; a starvation guard forces an IF grant after a bounded LSU streak.
- Sits between the IF/LSU stages and the unified memory interface. Sequences request issue, response wait and response routing.

Parameters:
STARVE_LIMIT, 4, max consecutive LSU grants while IF is pending before IF is forced (>=1)
TIMEOUT_CYCLES, 64, response watchdog limit (used only with ARB_RSP_TIMEOUT_EN)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
if_req_valid  in  1  fetch request
if_req_ready  out  1  fetch request accepted this cycle
if_addr  in  32  fetch address
if_rsp_valid  out  1  one-cycle fetch response pulse
if_rsp_data  out  32  fetch data
if_rsp_err  out  1  fetch error (timeout)
lsu_req_valid  in  1  LSU request
lsu_req_ready  out  1  LSU request accepted this cycle
lsu_we  in  1  1=store
lsu_be  in  4  byte enables
lsu_addr  in  32  LSU address
lsu_wdata  in  32  store data
lsu_rsp_valid  out  1  one-cycle LSU response pulse (loads and stores)
lsu_rsp_rdata  out  32  load data
lsu_rsp_err  out  1  LSU error (timeout)
mem_req_valid  out  1  request to memory
mem_req_ready  in  1  memory accepts request
mem_we  out  1  write
mem_be  out  4  byte enables
mem_addr  out  32  address
mem_wdata  out  32  write data
mem_rsp_valid  in  1  memory response, one per accepted request, reads and writes
mem_rsp_rdata  in  32  read data

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high.
- Reset values:
  - state=IDLE, streak=0.
  - All outputs 0: mem_req_valid, mem_we, mem_be, mem_addr, mem_wdata, all rsp_valid/rsp_data/rsp_err, both ready signals.
- FSM states: IDLE, ISSUE, WAIT_RSP, DRAIN.
- IDLE:
  - if_req_ready/lsu_req_ready are combinational and asserted only for the arbitration winner, only when that requester's valid is high.
  - On acceptance: latch owner, we, be, addr, wdata; go to ISSUE.
- Arbitration:
  - LSU wins if lsu_req_valid, unless streak==STARVE_LIMIT and if_req_valid, in which case IF wins.
  - streak increments on each LSU grant made while if_req_valid=1.
  - streak clears on any IF grant, or on an LSU grant with if_req_valid=0.
- Latched IF request fields:
  - mem_addr = {if_addr[31:2],2'b00}, mem_we=0, mem_be=4'hF, mem_wdata=0.
- Latched LSU request fields: passed unmodified.
- ISSUE:
  - mem_req_valid=1; fields held stable until mem_req_ready=1, then go to WAIT_RSP.
  - No new ready while not in IDLE.
  - mem_rsp_valid in ISSUE is ignored.
- WAIT_RSP:
  - On mem_rsp_valid, the owner's rsp_valid pulses for exactly one cycle in the next cycle.
  - The owner's rsp_data/rsp_rdata is captured from mem_rsp_rdata; the non-owner sees no pulse.
  - State returns to IDLE on the same edge.
- Latency:
  - Accept at N → mem_req_valid at N+1.
  - Memory ready at N+1 and response at N+2 → rsp pulse at N+3; the next accept can occur at N+3.
- Response data registers hold their value between pulses.
- mem_rsp_valid in IDLE is ignored.
- Reset mid-transaction: the transaction is dropped, no response is generated, and late memory responses are ignored.

Optional Feature:
ARB_RSP_TIMEOUT_EN
- Enabled:
  - A counter clears on entry to WAIT_RSP and increments each WAIT_RSP cycle.
  - If TIMEOUT_CYCLES WAIT_RSP cycles pass with no mem_rsp_valid, the owner gets an rsp_valid pulse on the next cycle with rsp_err=1 and data=0, and state goes to DRAIN.
  - DRAIN: no grants; the next mem_rsp_valid is discarded, then state goes to IDLE.
  - A normal response clears the counter, with err=0.
- Disabled:
  - WAIT_RSP waits indefinitely.
  - if_rsp_err and lsu_rsp_err are tied 0; DRAIN is unreachable.

Test Plan:
1. IF alone, if_addr=0x0000_1003, mem_req_ready=1, response 0xDEADBEEF one cycle after accept → mem_addr=0x0000_1000, mem_we=0, mem_be=F; if_rsp_valid pulse with 0xDEADBEEF; lsu_rsp_valid stays 0.
2. IF and LSU valid same cycle, LSU store addr=0x2000, be=0x3, wdata=0x1234 → lsu_req_ready=1, if_req_ready=0; memory sees the store; lsu_rsp_valid pulse; IF is granted in the next IDLE.
3. STARVE_LIMIT=4, both valid continuously, fixed-latency memory → grant order L,L,L,L,I,L,L,L,L,I.
4. mem_req_ready held 0 for 5 cycles in ISSUE → mem_* fields stable; no ready asserted; transaction completes after ready=1.
5. rst=1 for one cycle in WAIT_RSP, stray mem_rsp_valid two cycles later → no rsp pulses; the next IF request completes normally.
6. Macro on, TIMEOUT_CYCLES=8, LSU load, no response → lsu_rsp_valid=1, lsu_rsp_err=1, data 0 after 8 WAIT_RSP cycles; a subsequent mem_rsp_valid is discarded; then IDLE.
